// File: rtl/cdb_arbiter_rr_pkg.sv
// Shared CDB widths and types (sys_defs slice) plus the registered broadcast lane struct.
`ifndef PHYS_ZERO_REG
`define PHYS_ZERO_REG 6'd0
`endif

package cdb_arbiter_rr_pkg;
   localparam int PHYS_REG = 6;
   localparam int DATA     = 32;
   localparam int B_MASK   = 4;
   localparam int BS_PTR   = 2;

   localparam logic [PHYS_REG-1:0] ZERO_REG = `PHYS_ZERO_REG;

   typedef struct packed {
      logic                en;
      logic [PHYS_REG-1:0] rd;
      logic [DATA-1:0]     value;
      logic [B_MASK-1:0]   bmask;
   } CDB_LANE;

   localparam CDB_LANE LANE_IDLE = '{en: 1'b0, rd: ZERO_REG, value: '0, bmask: '0};

   // resolved-correct branch: its bit no longer guards anything
   function automatic logic [B_MASK-1:0] bmask_clear(input logic [B_MASK-1:0] m,
                                                     input logic [BS_PTR-1:0] p,
                                                     input logic en);
      return en ? (m & ~(B_MASK'(1) << p)) : m;
   endfunction
endpackage

// File: rtl/cdb_arbiter_rr_rr_pick.sv
// First set request bit at or after ptr, wrapping past WIDTH-1 to 0; one-hot and index out.
module cdb_arbiter_rr_rr_pick #(
   parameter  int WIDTH = 8,
   localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx,
   output logic [WIDTH-1:0] gnt
);
   logic [IW-1:0] j;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = '0;
      for (int k = 0; k < WIDTH; k++) begin
         j = IW'((int'(ptr) + k) % WIDTH);
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
      gnt = found ? (WIDTH'(1) << idx) : '0;
   end
endmodule

// File: rtl/cdb_arbiter_rr.sv
// CDB arbiter: NUM_FUB result buffers onto CDB_WIDTH registered broadcast lanes, fixed priority
// below NUM_PRIO, round-robin above. Define CDB_STARVE_EN for per-FUB anti-starvation counters.
module cdb_arbiter_rr
   import cdb_arbiter_rr_pkg::*;
#(
   parameter int NUM_FUB    = 8,
   parameter int CDB_WIDTH  = 2,
   parameter int NUM_PRIO   = 2,
   parameter int STARVE_MAX = 7
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_FUB-1:0]                  fub_valid,
   input  logic [NUM_FUB-1:0][PHYS_REG-1:0]    fub_tagDest,
   input  logic [NUM_FUB-1:0][DATA-1:0]        fub_result,
   input  logic [NUM_FUB-1:0][B_MASK-1:0]      fub_bmask,
   input  logic                                br_pred_wrong,
   input  logic                                br_pred_right,
   input  logic [BS_PTR-1:0]                   br_bs_ptr,
   output logic [NUM_FUB-1:0]                  cdb_grant,
   output logic [CDB_WIDTH-1:0]                cdb_rd_en,
   output logic [CDB_WIDTH-1:0][PHYS_REG-1:0]  cdb_rd,
   output logic [CDB_WIDTH-1:0][DATA-1:0]      cdb_reg_value,
   output logic [CDB_WIDTH-1:0][B_MASK-1:0]    cdb_bmask
);
   localparam int IW = (NUM_FUB > 1) ? $clog2(NUM_FUB) : 1;
   localparam logic [IW-1:0]      RR_BASE   = IW'((NUM_PRIO < NUM_FUB) ? NUM_PRIO : 0);
   localparam logic [NUM_FUB-1:0] PRIO_MASK = NUM_FUB'((64'd1 << NUM_PRIO) - 64'd1);

   if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
      $error("STARVE_MAX must fit the 3-bit starvation counter (1..7)");
   end

   logic [NUM_FUB-1:0]                elig, starved;
   logic [IW-1:0]                     rr_ptr, rr_ptr_nxt, rr_last;
   logic                              rr_any;
   logic [CDB_WIDTH-1:0]              lane_found;
   logic [CDB_WIDTH-1:0][IW-1:0]      lane_idx;
   logic [CDB_WIDTH-1:0][NUM_FUB-1:0] lane_gnt;
   CDB_LANE [CDB_WIDTH-1:0]           lane_d, lane_q;

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_FUB; i++)
         elig[i] = fub_valid[i] && !(br_pred_wrong && fub_bmask[i][br_bs_ptr]);
   end

   for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane
      logic [NUM_FUB-1:0] rem, req, gnt;
      logic [IW-1:0]      ptr, idx;
      logic               found;

      if (k == 0) begin : g_head
         assign rem = elig;
      end else begin : g_tail
         assign rem = g_lane[k-1].rem & ~g_lane[k-1].gnt;
      end

      // starved FUBs first, then the fixed class, both lowest index first; else RR from rr_ptr
      always_comb begin
         req = rem & ~PRIO_MASK;
         ptr = rr_ptr;
         if (|(rem & starved)) begin
            req = rem & starved;
            ptr = '0;
         end else if (|(rem & PRIO_MASK)) begin
            req = rem & PRIO_MASK;
            ptr = '0;
         end
      end

      cdb_arbiter_rr_rr_pick #(.WIDTH(NUM_FUB)) u_pick (
         .req   (req),
         .ptr   (ptr),
         .found (found),
         .idx   (idx),
         .gnt   (gnt)
      );

      assign lane_found[k]    = found;
      assign lane_idx[k]      = idx;
      assign lane_gnt[k]      = gnt;
      assign cdb_rd_en[k]     = lane_q[k].en;
      assign cdb_rd[k]        = lane_q[k].rd;
      assign cdb_reg_value[k] = lane_q[k].value;
      assign cdb_bmask[k]     = lane_q[k].bmask;
   end

   always_comb begin
      cdb_grant = '0;
      for (int k = 0; k < CDB_WIDTH; k++)
         cdb_grant = cdb_grant | lane_gnt[k];
   end

   // RR winners sit in scan order, so the last RR lane is the one the pointer moves past
   always_comb begin
      rr_any  = 1'b0;
      rr_last = rr_ptr;
      for (int k = 0; k < CDB_WIDTH; k++)
         if (lane_found[k] && int'(lane_idx[k]) >= NUM_PRIO) begin
            rr_any  = 1'b1;
            rr_last = lane_idx[k];
         end
      rr_ptr_nxt = rr_ptr;
      if (rr_any)
         rr_ptr_nxt = (int'(rr_last) == NUM_FUB - 1) ? RR_BASE : rr_last + 1'b1;
   end

   // Every lane reloads each cycle, so squash and bmask-clear of a held lane reduce to the idle fill.
   always_comb begin
      lane_d = {CDB_WIDTH{LANE_IDLE}};
      for (int k = 0; k < CDB_WIDTH; k++)
         if (lane_found[k]) begin
            lane_d[k].en    = 1'b1;
            lane_d[k].rd    = fub_tagDest[lane_idx[k]];
            lane_d[k].value = fub_result[lane_idx[k]];
            lane_d[k].bmask = bmask_clear(fub_bmask[lane_idx[k]], br_bs_ptr, br_pred_right);
         end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= RR_BASE;
         lane_q <= {CDB_WIDTH{LANE_IDLE}};
      end else begin
         rr_ptr <= rr_ptr_nxt;
         lane_q <= lane_d;
      end
   end

`ifdef CDB_STARVE_EN
   logic [NUM_FUB-1:0][2:0] starve_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_FUB; i++)
            if (cdb_grant[i])
               starve_cnt[i] <= 3'd0;
            else if (elig[i] && starve_cnt[i] != 3'd7)
               starve_cnt[i] <= starve_cnt[i] + 3'd1;
      end
   end

   always_comb begin
      starved = '0;
      for (int i = 0; i < NUM_FUB; i++)
         starved[i] = elig[i] && (starve_cnt[i] >= 3'(STARVE_MAX));
   end
`else
   assign starved = '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// Bench for cdb_arbiter_rr: 2-lane and 3-lane instances share stimulus, each checked against
// an order-list model (starved, fixed class, then RR scan from the model pointer).
module tb_cdb_arbiter_rr;
   import cdb_arbiter_rr_pkg::*;

   localparam int NF   = 8;
   localparam int NP   = 2;
   localparam int SMAX = 7;

   logic clk = 1'b0;
   logic rst_n;
   logic [NF-1:0]                fub_valid;
   logic [NF-1:0][PHYS_REG-1:0]  fub_tagDest;
   logic [NF-1:0][DATA-1:0]      fub_result;
   logic [NF-1:0][B_MASK-1:0]    fub_bmask;
   logic                         br_pred_wrong, br_pred_right;
   logic [BS_PTR-1:0]            br_bs_ptr;

   logic [NF-1:0]                gnt2, gnt3;
   logic [1:0]                   en2;
   logic [1:0][PHYS_REG-1:0]     rd2;
   logic [1:0][DATA-1:0]         val2;
   logic [1:0][B_MASK-1:0]       bm2;
   logic [2:0]                   en3;
   logic [2:0][PHYS_REG-1:0]     rd3;
   logic [2:0][DATA-1:0]         val3;
   logic [2:0][B_MASK-1:0]       bm3;

   int n_chk = 0;
   int n_err = 0;

   int                  mptr [2];
   int                  mcnt [2][NF];
   logic [NF-1:0]       e_gnt [2];
   logic                e_en  [2][3];
   logic [PHYS_REG-1:0] e_rd  [2][3];
   logic [DATA-1:0]     e_val [2][3];
   logic [B_MASK-1:0]   e_bm  [2][3];

   cdb_arbiter_rr #(.NUM_FUB(NF), .CDB_WIDTH(2), .NUM_PRIO(NP), .STARVE_MAX(SMAX)) u_dut2 (
      .clock(clk), .reset(rst_n), .fub_valid(fub_valid), .fub_tagDest(fub_tagDest),
      .fub_result(fub_result), .fub_bmask(fub_bmask), .br_pred_wrong(br_pred_wrong),
      .br_pred_right(br_pred_right), .br_bs_ptr(br_bs_ptr), .cdb_grant(gnt2),
      .cdb_rd_en(en2), .cdb_rd(rd2), .cdb_reg_value(val2), .cdb_bmask(bm2));

   cdb_arbiter_rr #(.NUM_FUB(NF), .CDB_WIDTH(3), .NUM_PRIO(NP), .STARVE_MAX(SMAX)) u_dut3 (
      .clock(clk), .reset(rst_n), .fub_valid(fub_valid), .fub_tagDest(fub_tagDest),
      .fub_result(fub_result), .fub_bmask(fub_bmask), .br_pred_wrong(br_pred_wrong),
      .br_pred_right(br_pred_right), .br_bs_ptr(br_bs_ptr), .cdb_grant(gnt3),
      .cdb_rd_en(en3), .cdb_rd(rd3), .cdb_reg_value(val3), .cdb_bmask(bm3));

   initial forever #5 clk = ~clk;

   always @(posedge clk)
      if (rst_n) assert (!(br_pred_wrong && br_pred_right)) else $error("wrong and right resolved together");

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mptr[d] = NP;
         for (int i = 0; i < NF; i++) mcnt[d][i] = 0;
         for (int k = 0; k < 3; k++) begin
            e_en[d][k] = 1'b0; e_rd[d][k] = ZERO_REG; e_val[d][k] = '0; e_bm[d][k] = '0;
         end
      end
   endtask

   task automatic model(input int d, input int w);
      int ord[$];
      bit taken [NF];
      bit el [NF];
      int last, ii;
      for (int i = 0; i < NF; i++) begin
         el[i]    = fub_valid[i] && !(br_pred_wrong && fub_bmask[i][br_bs_ptr]);
         taken[i] = 1'b0;
      end
`ifdef CDB_STARVE_EN
      for (int i = 0; i < NF; i++)
         if (el[i] && mcnt[d][i] >= SMAX) begin ord.push_back(i); taken[i] = 1'b1; end
`endif
      for (int i = 0; i < NP; i++)
         if (el[i] && !taken[i]) begin ord.push_back(i); taken[i] = 1'b1; end
      for (int k = 0; k < NF - NP; k++) begin
         ii = NP + (mptr[d] - NP + k) % (NF - NP);
         if (el[ii] && !taken[ii]) ord.push_back(ii);
      end
      while (ord.size() > w) void'(ord.pop_back());
      e_gnt[d] = '0;
      foreach (ord[j]) e_gnt[d][ord[j]] = 1'b1;
      for (int k = 0; k < w; k++) begin
         if (k < ord.size()) begin
            e_en[d][k]  = 1'b1;
            e_rd[d][k]  = fub_tagDest[ord[k]];
            e_val[d][k] = fub_result[ord[k]];
            e_bm[d][k]  = fub_bmask[ord[k]];
            if (br_pred_right) e_bm[d][k][br_bs_ptr] = 1'b0;
         end else begin
            e_en[d][k] = 1'b0; e_rd[d][k] = ZERO_REG; e_val[d][k] = '0; e_bm[d][k] = '0;
         end
      end
      last = -1;
      foreach (ord[j]) if (ord[j] >= NP) last = ord[j];
      if (last >= 0) mptr[d] = (last == NF - 1) ? NP : last + 1;
`ifdef CDB_STARVE_EN
      for (int i = 0; i < NF; i++)
         if (e_gnt[d][i]) mcnt[d][i] = 0;
         else if (el[i] && mcnt[d][i] < 7) mcnt[d][i]++;
`endif
   endtask

   task automatic chk_lanes(input string ph);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s w2 lane%0d en", ph, k),    64'(en2[k]),  64'(e_en[0][k]));
         chk($sformatf("%s w2 lane%0d rd", ph, k),    64'(rd2[k]),  64'(e_rd[0][k]));
         chk($sformatf("%s w2 lane%0d value", ph, k), 64'(val2[k]), 64'(e_val[0][k]));
         chk($sformatf("%s w2 lane%0d bmask", ph, k), 64'(bm2[k]),  64'(e_bm[0][k]));
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s w3 lane%0d en", ph, k),    64'(en3[k]),  64'(e_en[1][k]));
         chk($sformatf("%s w3 lane%0d rd", ph, k),    64'(rd3[k]),  64'(e_rd[1][k]));
         chk($sformatf("%s w3 lane%0d value", ph, k), 64'(val3[k]), 64'(e_val[1][k]));
         chk($sformatf("%s w3 lane%0d bmask", ph, k), 64'(bm3[k]),  64'(e_bm[1][k]));
      end
   endtask

   // inputs are set by the caller after posedge+1; grants sampled at negedge, lanes at posedge+1
   task automatic cyc(input string ph, input int want2 = -1);
      @(negedge clk);
      model(0, 2);
      model(1, 3);
      chk({ph, " w2 grant"}, 64'(gnt2), 64'(e_gnt[0]));
      chk({ph, " w3 grant"}, 64'(gnt3), 64'(e_gnt[1]));
      if (want2 >= 0) chk({ph, " w2 grant fixed"}, 64'(gnt2), 64'(want2));
      @(posedge clk);
      #1;
      chk_lanes(ph);
   endtask

   task automatic rnd_data();
      for (int i = 0; i < NF; i++) begin
         fub_tagDest[i] = PHYS_REG'($urandom);
         fub_result[i]  = $urandom;
         fub_bmask[i]   = B_MASK'($urandom);
      end
   endtask

   int fc_want [4] = '{8'h0C, 8'h30, 8'hC0, 8'h0C};
   int r;

   initial begin
      rst_n = 1'b0;
      fub_valid = '0; fub_tagDest = '0; fub_result = '0; fub_bmask = '0;
      br_pred_wrong = 1'b0; br_pred_right = 1'b0; br_bs_ptr = '0;
      model_reset();
      #12;
      chk_lanes("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // fixed class saturates both lanes
      fub_valid = 8'hFF; rnd_data();
      repeat (4) cyc("ff", 8'h03);

      // asynchronous reset while lanes are live
      chk("live before reset en2", 64'(en2), 64'd3);
      #2; rst_n = 1'b0; #1;
      chk("async reset en2", 64'(en2), 64'd0);
      chk("async reset en3", 64'(en3), 64'd0);
      chk("async reset rd2 lane0", 64'(rd2[0]), 64'(ZERO_REG));
      model_reset();
      fub_valid = '0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // round-robin class only: pairs rotate from FUB 2
      fub_valid = 8'hFC; rnd_data();
      foreach (fc_want[i]) cyc("fc", fc_want[i]);

      // squash: FUB 3 granted, then a matching mispredict kills the lane and blocks FUB 5
      fub_valid = 8'h08; rnd_data(); fub_bmask[3] = 4'b0100;
      cyc("sq0", 8'h08);
      fub_valid = 8'h20; fub_bmask[5] = 4'b0100; br_pred_wrong = 1'b1; br_bs_ptr = 2'd2;
      cyc("sq1", 8'h00);
      chk("squash lane0 en", 64'(en2[0]), 64'd0);
      br_pred_wrong = 1'b0;

      // correct prediction clears the resolved bit on capture
      fub_valid = 8'h10; rnd_data(); fub_bmask[4] = 4'b0010;
      cyc("pr0", 8'h10);
      chk("pr held bmask", 64'(bm2[0]), 64'd2);
      fub_result[4] = $urandom; br_pred_right = 1'b1; br_bs_ptr = 2'd1;
      cyc("pr1", 8'h10);
      chk("pr cleared bmask", 64'(bm2[0]), 64'd0);
      chk("pr rd_en kept", 64'(en2[0]), 64'd1);
      br_pred_right = 1'b0;

      // single request on the 3-lane instance
      fub_valid = 8'h01; rnd_data();
      cyc("w3");
      chk("w3 en vector", 64'(en3), 64'd1);
      chk("w3 lane0 tag", 64'(rd3[0]), 64'(fub_tagDest[0]));
      chk("w3 lane1 tag", 64'(rd3[1]), 64'(ZERO_REG));
      chk("w3 lane2 tag", 64'(rd3[2]), 64'(ZERO_REG));

      repeat (500) begin
         fub_valid = NF'($urandom);
         rnd_data();
         r = $urandom_range(0, 3);
         br_pred_wrong = (r == 0);
         br_pred_right = (r == 1);
         br_bs_ptr = BS_PTR'($urandom);
         cyc("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
